// File: rtl/ahb_default_agents_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_default_agents_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ or SEQ: a transfer that must be answered.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_def_slv_fsm.sv
// Default-slave response FSM: OKAY for IDLE/BUSY, two-cycle ERROR for
// NONSEQ/SEQ. Outputs decode from the state register only, so HREADYOUT
// can be fed back as HREADY without forming a combinational loop.
module ahb_def_slv_fsm
  import ahb_default_agents_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRST_N,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  input  logic       DefaultSlv,
  output logic       HREADYOUT,
  output logic [1:0] HRESP
);

  ds_state_e state, state_nxt;
  logic      sample_err;

  // A completed address phase to the default slave carrying a real transfer.
  assign sample_err = HREADY && DefaultSlv && htrans_active(HTRANS);

  // State register, asynchronous return to OKAY on reset.
  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) state <= DS_OKAY;
    else         state <= state_nxt;
  end

  // Next state; ERR2 may chain straight into a new error.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DS_OKAY: state_nxt = sample_err ? DS_ERR1 : DS_OKAY;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = sample_err ? DS_ERR1 : DS_OKAY;
      default: state_nxt = DS_OKAY;
    endcase
  end

  // Response decode from state only.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (state)
      DS_ERR1: begin HREADYOUT = 1'b0; HRESP = HRESP_ERROR; end
      DS_ERR2: begin HREADYOUT = 1'b1; HRESP = HRESP_ERROR; end
      default: begin HREADYOUT = 1'b1; HRESP = HRESP_OKAY;  end
    endcase
  end

endmodule

// File: rtl/ahb_default_agents.sv
// AHB-Lite default master (constant benign IDLE transfer) plus default
// slave (OKAY / two-cycle ERROR responder) for the interconnect mux.
module ahb_default_agents
  import ahb_default_agents_pkg::*;
#(
  parameter logic [2:0] DEF_HSIZE = HSIZE_WORD,
  parameter logic [3:0] DEF_HPROT = 4'b0001
) (
  input  logic        HCLK,
  input  logic        HRST_N,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic        DefaultSlv,
  output logic        DM_HLOCK,
  output logic [31:0] DM_HADDR,
  output logic [2:0]  DM_HSIZE,
  output logic        DM_HWRITE,
  output logic [1:0]  DM_HTRANS,
  output logic [2:0]  DM_HBURST,
  output logic [3:0]  DM_HPROT,
  output logic [31:0] DM_HWDATA,
  output logic        DS_HREADYOUT,
  output logic [1:0]  DS_HRESP,
  output logic [31:0] DS_HRDATA,
  output logic [15:0] DS_HSPLIT
);

  // Default master: permanently idle single-word read at address 0.
  assign DM_HLOCK  = 1'b0;
  assign DM_HADDR  = 32'h0;
  assign DM_HSIZE  = DEF_HSIZE;
  assign DM_HWRITE = 1'b0;
  assign DM_HTRANS = HTRANS_IDLE;
  assign DM_HBURST = HBURST_SINGLE;
  assign DM_HPROT  = DEF_HPROT;
  assign DM_HWDATA = 32'h0;

  // Default slave never returns data and never splits.
  assign DS_HRDATA = 32'h0;
  assign DS_HSPLIT = 16'h0;

  ahb_def_slv_fsm u_def_slv_fsm (
    .HCLK       (HCLK),
    .HRST_N     (HRST_N),
    .HTRANS     (HTRANS),
    .HREADY     (HREADY),
    .DefaultSlv (DefaultSlv),
    .HREADYOUT  (DS_HREADYOUT),
    .HRESP      (DS_HRESP)
  );

endmodule

// File: tb/tb_ahb_default_agents.sv
// Directed bench for ahb_default_agents.
module tb_ahb_default_agents;

  logic        HCLK;
  logic        HRST_N;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        DefaultSlv;
  logic        DM_HLOCK;
  logic [31:0] DM_HADDR;
  logic [2:0]  DM_HSIZE;
  logic        DM_HWRITE;
  logic [1:0]  DM_HTRANS;
  logic [2:0]  DM_HBURST;
  logic [3:0]  DM_HPROT;
  logic [31:0] DM_HWDATA;
  logic        DS_HREADYOUT;
  logic [1:0]  DS_HRESP;
  logic [31:0] DS_HRDATA;
  logic [15:0] DS_HSPLIT;

  int tests_run = 0;
  int tests_failed = 0;

  ahb_default_agents dut (
    .HCLK(HCLK), .HRST_N(HRST_N), .HTRANS(HTRANS), .HREADY(HREADY),
    .DefaultSlv(DefaultSlv),
    .DM_HLOCK(DM_HLOCK), .DM_HADDR(DM_HADDR), .DM_HSIZE(DM_HSIZE),
    .DM_HWRITE(DM_HWRITE), .DM_HTRANS(DM_HTRANS), .DM_HBURST(DM_HBURST),
    .DM_HPROT(DM_HPROT), .DM_HWDATA(DM_HWDATA),
    .DS_HREADYOUT(DS_HREADYOUT), .DS_HRESP(DS_HRESP),
    .DS_HRDATA(DS_HRDATA), .DS_HSPLIT(DS_HSPLIT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance past the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic rdy, input logic sel);
    @(negedge HCLK);
    HTRANS = tr; HREADY = rdy; DefaultSlv = sel;
  endtask

  task automatic test_reset();
    HRST_N = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; DefaultSlv = 1'b0;
    #3;
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_ds_resp: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    tests_run++;
    if (DS_HRDATA !== 32'h0 || DS_HSPLIT !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_ds_data: got rdata=%h split=%h want 0/0", DS_HRDATA, DS_HSPLIT);
    end
    tests_run++;
    if ({DM_HLOCK, DM_HADDR, DM_HSIZE, DM_HWRITE, DM_HTRANS, DM_HBURST, DM_HPROT, DM_HWDATA}
        !== {1'b0, 32'h0, 3'b010, 1'b0, 2'b00, 3'b000, 4'b0001, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_dm: got lock=%b addr=%h size=%b wr=%b tr=%b burst=%b prot=%b wdata=%h want 0/0/010/0/00/000/0001/0",
               DM_HLOCK, DM_HADDR, DM_HSIZE, DM_HWRITE, DM_HTRANS, DM_HBURST, DM_HPROT, DM_HWDATA);
    end
    // Qualifying inputs under reset must not move the FSM.
    HTRANS = 2'b10; DefaultSlv = 1'b1;
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_hold: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b1, 1'b0);
    HRST_N = 1'b1;
    tick();
  endtask

  task automatic test_nonseq();
    drive(2'b10, 1'b1, 1'b1);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b001) begin
      tests_failed++;
      $display("FAIL nonseq_err1: got rdy=%b resp=%b want rdy=0 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b10, 1'b0, 1'b1);   // bus stalled while in ERR1
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b101) begin
      tests_failed++;
      $display("FAIL nonseq_err2: got rdy=%b resp=%b want rdy=1 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b1, 1'b1);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL nonseq_okay: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    tests_run++;
    if (DS_HRDATA !== 32'h0 || DS_HSPLIT !== 16'h0) begin
      tests_failed++;
      $display("FAIL nonseq_data: got rdata=%h split=%h want 0/0", DS_HRDATA, DS_HSPLIT);
    end
  endtask

  task automatic test_idle_busy();
    logic [1:0] tr;
    for (int i = 0; i < 10; i++) begin
      tr = (i < 5) ? 2'b00 : 2'b01;
      drive(tr, 1'b1, 1'b1);
      tick();
      tests_run++;
      if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
        tests_failed++;
        $display("FAIL idle_busy[%0d] htrans=%b: got rdy=%b resp=%b want rdy=1 resp=00",
                 i, tr, DS_HREADYOUT, DS_HRESP);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b10, 1'b1, 1'b1);
    tick();                       // ERR1
    drive(2'b11, 1'b0, 1'b1);
    tick();                       // ERR2
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b101) begin
      tests_failed++;
      $display("FAIL b2b_err2: got rdy=%b resp=%b want rdy=1 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b11, 1'b1, 1'b1);     // SEQ completes during ERR2
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b001) begin
      tests_failed++;
      $display("FAIL b2b_err1_again: got rdy=%b resp=%b want rdy=0 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b101) begin
      tests_failed++;
      $display("FAIL b2b_err2_again: got rdy=%b resp=%b want rdy=1 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b1, 1'b0);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_okay: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
  endtask

  task automatic test_stall();
    drive(2'b10, 1'b0, 1'b1);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL stall_hready0: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b10, 1'b1, 1'b0);
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL stall_unselected: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
  endtask

  task automatic test_loop();
    // Toggle inputs between edges; outputs must hold until the rising edge.
    drive(2'b10, 1'b1, 1'b1);
    #1 HREADY = 1'b0;
    #1 HTRANS = 2'b11; HREADY = 1'b1;
    #1;
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL loop_okay_hold: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    tick();                       // SEQ sampled -> ERR1
    HTRANS = 2'b00; #1 HREADY = 1'b0; #1 HTRANS = 2'b10; #1 HREADY = 1'b1;
    #1;
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b001) begin
      tests_failed++;
      $display("FAIL loop_err1_hold: got rdy=%b resp=%b want rdy=0 resp=01", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b1, 1'b0);
    tick();                       // ERR2
    tick();                       // OKAY
  endtask

  task automatic test_reset_mid_err();
    drive(2'b10, 1'b1, 1'b1);
    tick();                       // ERR1
    drive(2'b00, 1'b0, 1'b0);
    #1 HRST_N = 1'b0;
    #1;                           // still before the next rising edge
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_mid_err1: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
    drive(2'b00, 1'b1, 1'b0);
    HRST_N = 1'b1;
    tick();
    tests_run++;
    if ({DS_HREADYOUT, DS_HRESP} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_mid_err1_after: got rdy=%b resp=%b want rdy=1 resp=00", DS_HREADYOUT, DS_HRESP);
    end
  endtask

  initial begin
    test_reset();
    test_nonseq();
    test_idle_busy();
    test_back_to_back();
    test_stall();
    test_loop();
    test_reset_mid_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
